bdu_feeder: RTL and testbench

Upstream driver for the bit-serial distance unit (BDU). Holds the current query point and accepts reference points over a valid/ready handshake. For each reference it clears the BDU, then streams query/reference bits MSB-first, interleaved x,y,z. It watches the BDU's `complete`, stops streaming on early termination or full completion, captures the BDU result, and presents it downstream (to the kNN list) over a second valid/ready handshake.

---
 rtl/bdu_feeder_pkg.sv | 16 +
 rtl/bdu_feeder_bit_sequencer.sv | 33 +++
 rtl/bdu_feeder.sv | 130 +++++++++++++
 tb/tb_bdu_feeder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdu_feeder_pkg.sv
// bdu_feeder_pkg: shared types and constants for the BDU feeder and its kNN result path.
package bdu_feeder_pkg;
  localparam int BIT_WIDTH = 32;
  localparam int DIST_W = 2 * BIT_WIDTH + 2;
  localparam logic [1:0] CODE_X = 2'b01;
  localparam logic [1:0] CODE_Y = 2'b10;
  localparam logic [1:0] CODE_Z = 2'b11;
  typedef struct packed {
    logic valid;
    logic [DIST_W-1:0] distance;
    logic [BIT_WIDTH-1:0] x;
    logic [BIT_WIDTH-1:0] y;
    logic [BIT_WIDTH-1:0] z;
  } knn_entry_t;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RESULT} feeder_state_e;
endpackage

// File: rtl/bdu_feeder_bit_sequencer.sv
// bit_sequencer: (dimension, bit index) counter walking x,y,z per bit, MSB = 1 .. LSB = BIT_WIDTH.
module bit_sequencer #(
  parameter int BIT_WIDTH = 32,
  parameter int BW = $clog2(BIT_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  output logic [1:0]    code,
  output logic [BW-1:0] b,
  output logic          last
);
  import bdu_feeder_pkg::*;
  logic [1:0] code_q, code_d;
  logic [BW-1:0] b_q, b_d;
  always_comb begin
    code_d = start ? CODE_X : advance ? (code_q == CODE_Z ? CODE_X : code_q + 2'd1) : code_q;
    b_d = start ? BW'(1) : (advance && code_q == CODE_Z) ? b_q + BW'(1) : b_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 2'b00;
      b_q <= '0;
    end else begin
      code_q <= code_d;
      b_q <= b_d;
    end
  end
  assign code = code_q;
  assign b = b_q;
  assign last = code_q == CODE_Z && b_q == BW'(BIT_WIDTH);
endmodule

// File: rtl/bdu_feeder.sv
// bdu_feeder: streams query/reference bits into the BDU and hands its result to the kNN list.
module bdu_feeder #(
  parameter int BIT_WIDTH = bdu_feeder_pkg::BIT_WIDTH,
  parameter int BW = $clog2(BIT_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        q_load,
  input  logic [BIT_WIDTH-1:0]        q_x,
  input  logic [BIT_WIDTH-1:0]        q_y,
  input  logic [BIT_WIDTH-1:0]        q_z,
  input  logic                        ref_valid,
  output logic                        ref_ready,
  input  logic [BIT_WIDTH-1:0]        ref_x,
  input  logic [BIT_WIDTH-1:0]        ref_y,
  input  logic [BIT_WIDTH-1:0]        ref_z,
  output logic                        bdu_clr,
  output logic                        bdu_valid,
  output logic                        bdu_q_bit,
  output logic                        bdu_r_bit,
  output logic [1:0]                  bdu_code,
  output logic [BW-1:0]               bdu_b,
  input  logic                        bdu_complete,
  input  bdu_feeder_pkg::knn_entry_t  bdu_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output bdu_feeder_pkg::knn_entry_t  res_entry,
  output logic [15:0]                 term_count
);
  import bdu_feeder_pkg::*;
  feeder_state_e state_q, state_d;
  logic q_loaded_q, q_loaded_d;
  logic [BIT_WIDTH-1:0] qx_q, qy_q, qz_q, qx_d, qy_d, qz_d;
  logic [BIT_WIDTH-1:0] rx_q, ry_q, rz_q, rx_d, ry_d, rz_d;
  knn_entry_t res_q, res_d;
  logic [15:0] term_q, term_d;
  logic start, advance, last, stream;
  logic [1:0] code;
  logic [BIT_WIDTH-1:0] q_sel, r_sel, q_sh, r_sh;

  bit_sequencer #(.BIT_WIDTH(BIT_WIDTH), .BW(BW)) u_seq (
    .clk(clk), .rst(rst), .start(start), .advance(advance),
    .code(code), .b(bdu_b), .last(last)
  );

  // Shifting left by b-1 puts bit (BIT_WIDTH - b) in the MSB position.
  always_comb begin
    q_sel = code == CODE_X ? qx_q : code == CODE_Y ? qy_q : qz_q;
    r_sel = code == CODE_X ? rx_q : code == CODE_Y ? ry_q : rz_q;
    q_sh = q_sel << (bdu_b - BW'(1));
    r_sh = r_sel << (bdu_b - BW'(1));
  end

  assign stream = state_q == S_STREAM;
  assign ref_ready = state_q == S_IDLE && q_loaded_q;
  assign bdu_clr = state_q == S_CLEAR;
  assign bdu_valid = stream && !bdu_complete;
  assign bdu_q_bit = stream && q_sh[BIT_WIDTH-1];
  assign bdu_r_bit = stream && r_sh[BIT_WIDTH-1];
  assign bdu_code = stream ? code : 2'b00;
  assign res_valid = state_q == S_RESULT;
  assign res_entry = res_q;
  assign term_count = term_q;

  always_comb begin
    state_d = state_q;
    q_loaded_d = q_loaded_q;
    {qx_d, qy_d, qz_d} = {qx_q, qy_q, qz_q};
    {rx_d, ry_d, rz_d} = {rx_q, ry_q, rz_q};
    res_d = res_q;
    term_d = term_q;
    start = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (q_load) begin
          q_loaded_d = 1'b1;
          {qx_d, qy_d, qz_d} = {q_x, q_y, q_z};
        end
        if (ref_valid && ref_ready) begin
          {rx_d, ry_d, rz_d} = {ref_x, ref_y, ref_z};
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        start = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (bdu_complete) begin
          res_d = bdu_out;
          state_d = S_RESULT;
        end else if (last) begin
          state_d = S_DRAIN;
        end else begin
          advance = 1'b1;
        end
      end
      S_DRAIN: begin
        res_d = bdu_out;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
          term_d = (!res_q.valid && term_q != 16'hFFFF) ? term_q + 16'd1 : term_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_loaded_q <= 1'b0;
      {qx_q, qy_q, qz_q} <= '0;
      {rx_q, ry_q, rz_q} <= '0;
      res_q <= '0;
      term_q <= '0;
    end else begin
      state_q <= state_d;
      q_loaded_q <= q_loaded_d;
      {qx_q, qy_q, qz_q} <= {qx_d, qy_d, qz_d};
      {rx_q, ry_q, rz_q} <= {rx_d, ry_d, rz_d};
      res_q <= res_d;
      term_q <= term_d;
    end
  end
endmodule

// File: tb/tb_bdu_feeder.sv
// tb_bdu_feeder: directed bench for bdu_feeder at BIT_WIDTH = 8 with a behavioural BDU model.
module tb_bdu_feeder;
  import bdu_feeder_pkg::*;
  localparam int W = 8;
  localparam int BW = $clog2(W + 1);
  logic clk = 1'b0, rst = 1'b1, q_load = 1'b0, ref_valid = 1'b0, res_ready = 1'b0, kill = 1'b0;
  logic [W-1:0] q_x = '0, q_y = '0, q_z = '0, ref_x = '0, ref_y = '0, ref_z = '0;
  logic ref_ready, bdu_clr, bdu_valid, bdu_q_bit, bdu_r_bit, bdu_complete, res_valid;
  logic [1:0] bdu_code;
  logic [BW-1:0] bdu_b;
  logic [15:0] term_count;
  knn_entry_t bdu_out, res_entry;
  int checks = 0, errors = 0, cyc = 0, thr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bdu_feeder #(.BIT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_x(q_x), .q_y(q_y), .q_z(q_z),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .bdu_clr(bdu_clr), .bdu_valid(bdu_valid), .bdu_q_bit(bdu_q_bit), .bdu_r_bit(bdu_r_bit),
    .bdu_code(bdu_code), .bdu_b(bdu_b), .bdu_complete(bdu_complete), .bdu_out(bdu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_entry(res_entry), .term_count(term_count)
  );

  // BDU model: shifts in bit prefixes per dimension and terminates once the
  // smallest distance still reachable from those prefixes exceeds thr.
  logic [W-1:0] mq [3];
  logic [W-1:0] mr [3];
  int mcnt, lb_sum;

  function automatic int lb_of(logic [W-1:0] a, logic [W-1:0] b, int k);
    int df = (a > b) ? int'(a - b) : int'(b - a);
    int m = W - k;
    return df == 0 ? 0 : (df << m) - ((1 << m) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst || bdu_clr) begin
      for (int d = 0; d < 3; d++) begin
        mq[d] <= '0;
        mr[d] <= '0;
      end
      mcnt <= 0;
    end else if (bdu_valid) begin
      mq[bdu_code - 2'd1] <= {mq[bdu_code - 2'd1][W-2:0], bdu_q_bit};
      mr[bdu_code - 2'd1] <= {mr[bdu_code - 2'd1][W-2:0], bdu_r_bit};
      mcnt <= mcnt + 1;
    end
  end

  always_comb begin
    lb_sum = 0;
    for (int d = 0; d < 3; d++)
      lb_sum = lb_sum + lb_of(mq[d], mr[d], mcnt / 3 + ((d < mcnt % 3) ? 1 : 0))
                      * lb_of(mq[d], mr[d], mcnt / 3 + ((d < mcnt % 3) ? 1 : 0));
  end

  assign bdu_complete = kill || lb_sum > thr || mcnt == 3 * W;
  assign bdu_out = '{valid: (mcnt == 3 * W) && (lb_sum <= thr), distance: DIST_W'(lb_sum),
                     x: BIT_WIDTH'(mr[0]), y: BIT_WIDTH'(mr[1]), z: BIT_WIDTH'(mr[2])};

  // Stream monitor, sampled mid-cycle.
  int pulses = 0;
  logic [3*W-1:0] qv = '0;
  logic [1:0] codes [3*W];
  logic [BW-1:0] bs [3*W];
  always @(negedge clk) begin
    if (bdu_clr) begin
      pulses <= 0;
      qv <= '0;
    end else if (bdu_valid && pulses < 3 * W) begin
      qv <= qv | ((3*W)'(bdu_q_bit) << pulses);
      codes[pulses] <= bdu_code;
      bs[pulses] <= bdu_b;
      pulses <= pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_q(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    {q_x, q_y, q_z} = {x, y, z};
    q_load = 1'b1;
    tick();
    q_load = 1'b0;
  endtask

  task automatic send_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                          output int t0);
    int n = 0;
    {ref_x, ref_y, ref_z} = {x, y, z};
    ref_valid = 1'b1;
    while (!ref_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ref_ready_wait", 64'(ref_ready), 64'(1));
    t0 = cyc;
    tick();
    ref_valid = 1'b0;
  endtask

  task automatic wait_res(input int t0, output int lat);
    int n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("res_valid_wait", 64'(res_valid), 64'(1));
    lat = cyc - t0;
  endtask

  task automatic accept;
    res_ready = 1'b1;
    chk("ref_ready_in_result", 64'(ref_ready), 64'(0));
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_accept", 64'(res_valid), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ref_ready"}, 64'(ref_ready), 64'(0));
    chk({tag, "_bdu_valid"}, 64'(bdu_valid), 64'(0));
    chk({tag, "_bdu_clr"}, 64'(bdu_clr), 64'(0));
    chk({tag, "_bdu_code"}, 64'(bdu_code), 64'(0));
    chk({tag, "_bdu_b"}, 64'(bdu_b), 64'(0));
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_dist"}, 64'(res_entry.distance), 64'(0));
    chk({tag, "_term"}, 64'(term_count), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    int t0, lat;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");
    // No query loaded yet: the offered reference must be refused.
    ref_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_query_ref_ready", 64'(ref_ready), 64'(0));
    end
    ref_valid = 1'b0;

    // Bit order and full-length result.
    thr = 200000;
    load_q(8'h80, 8'h00, 8'h01);
    send_ref(8'h00, 8'h00, 8'h00, t0);
    wait_res(t0, lat);
    chk("order_latency", 64'(lat), 64'(27));
    chk("order_pulses", 64'(pulses), 64'(24));
    chk("order_qbits", 64'(qv), 64'(24'h800001));
    for (int i = 0; i < 3 * W; i++) begin
      chk("order_code", 64'(codes[i]), 64'(i % 3 + 1));
      chk("order_b", 64'(bs[i]), 64'(i / 3 + 1));
    end
    chk("order_valid", 64'(res_entry.valid), 64'(1));
    chk("order_dist", 64'(res_entry.distance), 64'(16385));
    accept();

    // Full computation with backpressure.
    thr = 1000;
    load_q(8'd3, 8'd4, 8'd0);
    send_ref(8'd0, 8'd0, 8'd0, t0);
    wait_res(t0, lat);
    chk("full_latency", 64'(lat), 64'(27));
    chk("full_pulses", 64'(pulses), 64'(24));
    chk("full_valid", 64'(res_entry.valid), 64'(1));
    chk("full_x", 64'(res_entry.x), 64'(0));
    chk("full_y", 64'(res_entry.y), 64'(0));
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", 64'(res_valid), 64'(1));
      chk("bp_dist", 64'(res_entry.distance), 64'(25));
      chk("bp_ref_ready", 64'(ref_ready), 64'(0));
      tick();
    end
    accept();
    chk("full_term", 64'(term_count), 64'(0));

    // Early termination: the second x bit pushes the bound past 1.
    thr = 1;
    load_q(8'd255, 8'd0, 8'd0);
    send_ref(8'd0, 8'd0, 8'd0, t0);
    wait_res(t0, lat);
    chk("early_latency", 64'(lat), 64'(7));
    chk("early_pulses", 64'(pulses), 64'(4));
    chk("early_valid", 64'(res_entry.valid), 64'(0));
    accept();
    chk("early_term", 64'(term_count), 64'(1));

    // Query load during STREAM is ignored.
    thr = 200000;
    load_q(8'h80, 8'h00, 8'h01);
    send_ref(8'h00, 8'h00, 8'h00, t0);
    tick();
    tick();
    {q_x, q_y, q_z} = {8'h55, 8'hAA, 8'h33};
    q_load = 1'b1;
    tick();
    q_load = 1'b0;
    wait_res(t0, lat);
    chk("ignore_pulses", 64'(pulses), 64'(24));
    chk("ignore_qbits", 64'(qv), 64'(24'h800001));
    chk("ignore_dist", 64'(res_entry.distance), 64'(16385));
    accept();

    // Complete already high in the first STREAM cycle.
    kill = 1'b1;
    send_ref(8'h00, 8'h00, 8'h00, t0);
    wait_res(t0, lat);
    chk("kill_latency", 64'(lat), 64'(3));
    chk("kill_pulses", 64'(pulses), 64'(0));
    chk("kill_valid", 64'(res_entry.valid), 64'(0));
    kill = 1'b0;
    accept();
    chk("kill_term", 64'(term_count), 64'(2));

    // Reset at STREAM cycle 10.
    send_ref(8'h00, 8'h00, 8'h00, t0);
    for (int i = 0; i < 10; i++) tick();
    chk("mid_stream_valid", 64'(bdu_valid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    ref_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_query", 64'(ref_ready), 64'(0));
    end
    ref_valid = 1'b0;
    load_q(8'h80, 8'h00, 8'h01);
    chk("reload_ref_ready", 64'(ref_ready), 64'(1));
    send_ref(8'd1, 8'd2, 8'd3, t0);
    wait_res(t0, lat);
    chk("reload_latency", 64'(lat), 64'(27));
    chk("reload_dist", 64'(res_entry.distance), 64'(16137));
    chk("reload_x", 64'(res_entry.x), 64'(1));
    chk("reload_y", 64'(res_entry.y), 64'(2));
    chk("reload_z", 64'(res_entry.z), 64'(3));
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
